// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers, with busy for stall generation.
// Define MDU_ITERATIVE_DIV_EN to replace the fixed-latency divide with a 32-cycle shift-subtract divider.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  read,
  output logic        busy,
  output logic [31:0] out
);
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef MDU_ITERATIVE_DIV_EN
  localparam int DIV_LAT = 32;
`else
  localparam int DIV_LAT = DIV_CYCLES;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic        busy_q, busy_d;

  logic        op_signed;
  logic [31:0] abs_a, abs_b, q_mag, r_mag;
  logic [63:0] prod;

  assign op_signed = ~func[0];
  assign abs_a = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (op_signed && b[31]) ? (~b + 32'd1) : b;
  assign prod  = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

`ifdef MDU_ITERATIVE_DIV_EN
  // a_q shifts the dividend magnitude out MSB-first while quotient bits shift in.
  logic [31:0] rem_q, rem_d;
  logic [32:0] rem_sh, rem_sub;
  logic        ge;
  assign rem_sh  = {rem_q, a_q[31]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign ge      = (rem_sh >= {1'b0, b_q});
  assign q_mag   = {a_q[30:0], ge};
  assign r_mag   = ge ? rem_sub[31:0] : rem_sh[31:0];
`else
  // Operands are held as magnitudes, so unsigned division avoids the INT_MIN/-1 overflow case.
  assign q_mag = (b_q == 32'd0) ? 32'd0 : (a_q / b_q);
  assign r_mag = (b_q == 32'd0) ? 32'd0 : (a_q % b_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
`ifdef MDU_ITERATIVE_DIV_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (func)
            F_MTHI: hi_d = a;
            F_MTLO: lo_d = a;
            F_MULT, F_MULTU: begin
              state_d = MUL;
              cnt_d   = 32'(MULT_CYCLES - 1);
              a_d     = a;
              b_d     = b;
              sgn_d   = op_signed;
              busy_d  = 1'b1;
            end
            F_DIV, F_DIVU: begin
              state_d = DIV;
              cnt_d   = 32'(DIV_LAT - 1);
              a_d     = abs_a;
              b_d     = abs_b;
              qneg_d  = op_signed & (a[31] ^ b[31]);
              rneg_d  = op_signed & a[31];
              busy_d  = 1'b1;
`ifdef MDU_ITERATIVE_DIV_EN
              rem_d   = 32'd0;
`endif
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 32'd0;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 32'd1;
`ifdef MDU_ITERATIVE_DIV_EN
        a_d   = q_mag;
        rem_d = r_mag;
`endif
        if (cnt_q == 32'd0) begin
          // Divide by zero leaves HI/LO untouched but still takes the full latency.
          if (b_q != 32'd0) begin
            lo_d = qneg_q ? (~q_mag + 32'd1) : q_mag;
            hi_d = rneg_q ? (~r_mag + 32'd1) : r_mag;
          end
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MDU_ITERATIVE_DIV_EN
      rem_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
`ifdef MDU_ITERATIVE_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign out  = (read == 2'b01) ? hi_q :
                (read == 2'b10) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed cases then random ops against a longint arithmetic model.
module tb_mdu_core;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam int N_MUL = 5;
`ifdef MDU_ITERATIVE_DIV_EN
  localparam int N_DIV = 32;
`else
  localparam int N_DIV = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  func;
  logic [31:0] a, b;
  logic [1:0]  read;
  logic        busy;
  logic [31:0] out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func),
    .a(a), .b(b), .read(read), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one op on HI/LO, plus its busy length.
  task automatic model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    longint sx, sy, p, q, r;
    logic   sg;
    lat = 0;
    sg  = (f == F_MULT) || (f == F_DIV);
    sx  = sg ? longint'($signed(x)) : longint'({32'd0, x});
    sy  = sg ? longint'($signed(y)) : longint'({32'd0, y});
    case (f)
      F_MTHI: m_hi = x;
      F_MTLO: m_lo = x;
      F_MULT, F_MULTU: begin
        p = sx * sy;
        m_hi = p[63:32];
        m_lo = p[31:0];
        lat = N_MUL;
      end
      F_DIV, F_DIVU: begin
        lat = N_DIV;
        if (y != 32'd0) begin
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic read_check(input string tag);
    read = 2'b01; #1;
    chk({tag, " HI"}, out, m_hi);
    read = 2'b10; #1;
    chk({tag, " LO"}, out, m_lo);
  endtask

  // Issue one op, measure busy length, then verify HI/LO. collide re-pulses start mid-op.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input bit collide);
    int lat;
    int cyc;
    start = 1'b1; func = f; a = x; b = y; read = 2'b01;
    #1 chk({tag, " old HI before edge"}, out, m_hi);
    model(f, x, y, lat);
    @(posedge clk); #1;
    start = 1'b0; func = 6'($urandom()); a = $urandom(); b = $urandom();
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (collide && cyc == 1) begin
        start = 1'b1; func = F_MULT; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 32'(cyc), 32'(lat));
    read_check(tag);
    $display("op %s func=%b a=%h b=%h -> HI=%h LO=%h busy=%0d", tag, f, x, y, m_hi, m_lo, cyc);
  endtask

  initial begin
    logic [5:0]  funcs [7];
    logic [5:0]  f;
    logic [31:0] x, y;
    funcs = '{F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b100000};

    reset = 1'b0; start = 1'b0; func = 6'd0; a = 32'd0; b = 32'd0; read = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      read = 2'(r); #1;
      chk("reset out", out, 32'd0);
    end
    reset = 1'b1;

    do_op("mthi", F_MTHI, 32'h12345678, 32'd0, 0);
    do_op("mtlo", F_MTLO, 32'hCAFEBABE, 32'd0, 0);
    read = 2'b00; #1 chk("read 00", out, 32'd0);
    read = 2'b11; #1 chk("read 11", out, 32'd0);

    do_op("mult", F_MULT, 32'hFFFFFFFF, 32'h00000002, 0);
    chk("mult HI const", m_hi, 32'hFFFFFFFF);
    do_op("multu", F_MULTU, 32'hFFFFFFFF, 32'h00000002, 0);
    do_op("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 0);
    do_op("divu 7/2", F_DIVU, 32'd7, 32'd2, 0);
    do_op("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op("div by 0", F_DIV, 32'd5, 32'd0, 0);
    do_op("mult collide", F_MULT, 32'd3, 32'd4, 1);
    do_op("back-to-back", F_MULTU, 32'd6, 32'd7, 0);

    // Reset two cycles into a divide must abort with no late write.
    start = 1'b1; func = F_DIVU; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    read_check("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("post-abort busy", {31'd0, busy}, 32'd0);
    read_check("post-abort");

    for (int i = 0; i < 40; i++) begin
      f = funcs[$urandom_range(0, 6)];
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom();
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom();
      if ($urandom_range(0, 1) == 1) y = -y;
      do_op("random", f, x, y, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_core.md
# mdu_core

Multiply/divide unit for the EX stage, sitting directly downstream of the MDU controller. Accepts a one-cycle start pulse with the EX-stage funct code and operands, runs multiply or divide as a multi-cycle operation under a counter, and holds the HI/LO architectural registers. It reports `busy` back to the controller for stall generation and returns HI or LO on the read select.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1); unused when `MDU_ITERATIVE_DIV_EN` is defined.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle request; funct and operands valid with it.
- `func`  in  6  EX-stage funct: 010001 mthi, 010011 mtlo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `read`  in  2  01 = HI, 10 = LO, other = 0.
- `busy`  out  1  multi-cycle operation in progress.
- `out`  out  32  combinational read of HI/LO per `read`.

## Operation
- FSM states: IDLE, MUL, DIV.
- IDLE + `start`:
  - mthi/mtlo: write `a` to HI/LO at that edge; stay IDLE, `busy` stays 0.
  - mult/multu/div/divu: latch `a`, `b` and signedness; load counter; go to MUL/DIV.
  - Any other funct: ignored.
- MUL/DIV: counter decrements each cycle; on the final cycle HI/LO are written and the FSM returns to IDLE.
- `start` while not IDLE: ignored. The controller never issues this; the bench checks it anyway.
- Multiply: 64-bit product. multu is zero-extended, mult is two's-complement. HI = [63:32], LO = [31:0].
- Divide: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero: HI and LO unchanged; latency is normal.
- `out` is combinational from HI/LO; a read issued in the same cycle as a write returns the old value.

## Timing
- Reset values: HI = 0, LO = 0, state IDLE, counter 0, `busy` = 0, `out` = 0 for any `read`.
- `start` sampled at edge T. `busy` = 1 for cycles T+1 … T+N, with N = MULT_CYCLES or DIV_CYCLES.
- At edge T+N, HI/LO are updated and `busy` falls together. HI/LO first read new in cycle T+N+1.
- mthi/mtlo: new value visible in cycle T+1; `busy` never rises.
- Back-to-back: `start` in the first cycle after `busy` falls is accepted.
- Reset asserted mid-operation: immediate abort, all registers cleared, no partial HI/LO write.

## Configuration
- Macro: `MDU_ITERATIVE_DIV_EN`.
- Defined:
  - div/divu use a restoring shift-subtract divider, one quotient bit per cycle, on operand magnitudes; signs are fixed on the final cycle.
  - Latency is exactly 32 busy cycles; `DIV_CYCLES` is ignored.
- Undefined: quotient/remainder come from behavioural `/` and `%` on the latched operands, written after `DIV_CYCLES`.
- Results are bit-identical in both builds; only divide latency differs.

## Test plan
- Reset, then mthi 0x12345678 and mtlo 0xCAFEBABE; read=01 → 0x12345678, read=10 → 0xCAFEBABE; `busy` never asserts.
- mult 0xFFFFFFFF × 0x00000002 → HI 0xFFFFFFFF, LO 0xFFFFFFFE. Same operands with multu → HI 0x00000001, LO 0xFFFFFFFE. `busy` high exactly 5 cycles.
- div −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. divu 7 / 2 → LO 3, HI 1. `busy` high 10 cycles, or 32 with `MDU_ITERATIVE_DIV_EN`.
- div 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0. Then div 5 / 0 → HI/LO unchanged.
- Pulse mult 3 × 4 start again mid-operation with different operands → ignored; final LO = 12. New start accepted in the cycle after `busy` falls.
- Assert reset two cycles into a divide → `busy` = 0 immediately, HI = LO = 0, no later write.
